// File: rtl/lsu_dmem_ctrl.sv
// Memory-stage load/store controller in front of the 1 KiB byte-addressable dmem.
// Optional macro LSU_MISALIGN_TRAP_EN turns misaligned half/word accesses into faults.
module lsu_dmem_ctrl #(
  parameter logic [31:0] DMEM_BASE  = 32'h0001_0000,
  parameter int          DMEM_BYTES = 1024,
  parameter int          AW         = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [1:0]    req_size,
  input  logic          req_unsigned,
  input  logic [31:0]   req_addr,
  input  logic [31:0]   req_wdata,
  input  logic [4:0]    req_rd,
  output logic          dmem_we,
  output logic [1:0]    dmem_size,
  output logic [AW-1:0] dmem_addr,
  output logic [31:0]   dmem_wdata,
  input  logic [31:0]   dmem_rdata,
  output logic          resp_valid,
  input  logic          resp_ready,
  output logic [31:0]   resp_data,
  output logic [4:0]    resp_rd,
  output logic          resp_err
);

  typedef enum logic [1:0] {IDLE, LOAD_WAIT, RESP} state_t;

  state_t state, state_nxt;

  logic [AW-1:0] addr_q;
  logic [1:0]    size_q;
  logic          uns_q;

  logic          accept;
  logic [AW-1:0] req_offset;
  logic [32:0]   req_bytes;
  logic [32:0]   req_end;
  logic          range_fault;
  logic          size_fault;
  logic          misalign_fault;
  logic          fault;
  logic [31:0]   load_ext;

  localparam logic [32:0] BASE33  = {1'b0, DMEM_BASE};
  localparam logic [32:0] LIMIT33 = {1'b0, DMEM_BASE} + 33'(DMEM_BYTES);

  assign accept     = (state == IDLE) && req_valid;
  assign req_offset = req_addr[AW-1:0] - DMEM_BASE[AW-1:0];

  // Fault detection is done in 33 bits so an access near 2^32 cannot wrap into range.
  always_comb begin
    req_bytes = 33'd4;
    case (req_size)
      2'b00:   req_bytes = 33'd1;
      2'b01:   req_bytes = 33'd2;
      default: req_bytes = 33'd4;
    endcase
    req_end     = {1'b0, req_addr} + req_bytes;
    range_fault = ({1'b0, req_addr} < BASE33) || (req_end > LIMIT33);
    size_fault  = (req_size == 2'b11);
`ifdef LSU_MISALIGN_TRAP_EN
    misalign_fault = ((req_size == 2'b01) && req_addr[0]) ||
                     ((req_size == 2'b10) && (req_addr[1:0] != 2'b00));
`else
    misalign_fault = 1'b0;
`endif
    fault = range_fault || size_fault || misalign_fault;
  end

  // dmem already places the addressed byte at bit 0, so extraction is only masking.
  always_comb begin
    load_ext = dmem_rdata;
    case (size_q)
      2'b00:   load_ext = uns_q ? {24'h0, dmem_rdata[7:0]}
                                : {{24{dmem_rdata[7]}}, dmem_rdata[7:0]};
      2'b01:   load_ext = uns_q ? {16'h0, dmem_rdata[15:0]}
                                : {{16{dmem_rdata[15]}}, dmem_rdata[15:0]};
      default: load_ext = dmem_rdata;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) state_nxt = (fault || req_we) ? RESP : LOAD_WAIT;
      end
      LOAD_WAIT: state_nxt = RESP;
      RESP: begin
        if (resp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q    <= '0;
      size_q    <= 2'b00;
      uns_q     <= 1'b0;
      resp_rd   <= 5'd0;
      resp_err  <= 1'b0;
      resp_data <= 32'h0;
    end else if (accept) begin
      addr_q    <= req_offset;
      size_q    <= req_size;
      uns_q     <= req_unsigned;
      resp_rd   <= req_rd;
      resp_err  <= fault;
      resp_data <= 32'h0;
    end else if (state == LOAD_WAIT) begin
      resp_data <= load_ext;
    end
  end

  // In IDLE the request drives dmem directly so a store writes in its accept cycle.
  always_comb begin
    req_ready  = (state == IDLE);
    resp_valid = (state == RESP);
    dmem_we    = accept && req_we && !fault;
    dmem_addr  = (state == IDLE) ? req_offset : addr_q;
    dmem_size  = (state == IDLE) ? req_size : size_q;
    dmem_wdata = req_wdata;
  end

endmodule

// File: tb/tb_lsu_dmem_ctrl.sv
// Directed testbench for lsu_dmem_ctrl with a byte-addressed registered-read dmem model.
// Misalign expectations follow LSU_MISALIGN_TRAP_EN.
module tb_lsu_dmem_ctrl;

  localparam logic [31:0] BASE = 32'h0001_0000;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [4:0]  req_rd;
  logic        dmem_we;
  logic [1:0]  dmem_size;
  logic [9:0]  dmem_addr;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_data;
  logic [4:0]  resp_rd;
  logic        resp_err;

  int checks;
  int failures;
  int we_count;

  logic [7:0] mem [0:1023];

  lsu_dmem_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_rd(req_rd),
    .dmem_we(dmem_we), .dmem_size(dmem_size), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .resp_rd(resp_rd), .resp_err(resp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // dmem model: byte writes by size, registered 4-byte read starting at the addressed byte.
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 1024; i++) mem[i] <= 8'h00;
      dmem_rdata <= 32'h0;
    end else begin
      if (dmem_we) begin
        mem[dmem_addr] <= dmem_wdata[7:0];
        if (dmem_size != 2'b00) mem[dmem_addr + 10'd1] <= dmem_wdata[15:8];
        if (dmem_size == 2'b10) begin
          mem[dmem_addr + 10'd2] <= dmem_wdata[23:16];
          mem[dmem_addr + 10'd3] <= dmem_wdata[31:24];
        end
      end
      dmem_rdata <= {mem[dmem_addr + 10'd3], mem[dmem_addr + 10'd2],
                     mem[dmem_addr + 10'd1], mem[dmem_addr]};
    end
  end

  always @(posedge clk) begin
    if (rst_n && dmem_we) we_count++;
  end

  task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [4:0] rd, output logic [31:0] data,
                        output logic err, output logic [4:0] rdo, output int lat,
                        output logic we_acc);
    int guard;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata; req_rd = rd;
    #1;
    guard = 0;
    while (!req_ready && guard < 10) begin
      @(negedge clk); #1; guard++;
    end
    we_acc = dmem_we;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      lat++;
      if (resp_valid) break;
    end
    data = resp_data; err = resp_err; rdo = resp_rd;
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
  endtask

  task automatic test_reset();
    logic bad;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({resp_valid, resp_err, resp_rd, resp_data} !== 39'h0) begin
      failures++;
      $display("[TB] FAIL reset_resp got valid=%b err=%b rd=%h data=%h exp all 0",
               resp_valid, resp_err, resp_rd, resp_data);
    end
    checks++;
    if ({req_ready, dmem_we, dmem_size, dmem_addr} !== {1'b1, 1'b0, 2'b00, 10'h000}) begin
      failures++;
      $display("[TB] FAIL reset_ctrl got ready=%b we=%b size=%b addr=%h exp 1/0/00/000",
               req_ready, dmem_we, dmem_size, dmem_addr);
    end
    rst_n = 1'b1;

    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_unsigned = 1'b0;
    req_addr = BASE + 32'd8; req_wdata = 32'h0; req_rd = 5'd7;
    @(posedge clk); #1;
    req_valid = 1'b0;
    checks++;
    if ({resp_valid, req_ready} !== 2'b00) begin
      failures++;
      $display("[TB] FAIL load_wait_entry got valid=%b ready=%b exp 0/0", resp_valid, req_ready);
    end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({resp_valid, req_ready, dmem_we, resp_rd} !== {1'b0, 1'b1, 1'b0, 5'd0}) begin
      failures++;
      $display("[TB] FAIL mid_reset got valid=%b ready=%b we=%b rd=%h exp 0/1/0/00",
               resp_valid, req_ready, dmem_we, resp_rd);
    end
    @(negedge clk);
    rst_n = 1'b1;
    bad = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (resp_valid !== 1'b0 || req_ready !== 1'b1) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      failures++;
      $display("[TB] FAIL abandoned_load got a response or not ready, exp idle with no response");
    end
  endtask

  task automatic test_store_load();
    logic [31:0] d; logic e; logic [4:0] r; int lat; logic wa;
    do_req(1'b1, 2'b10, 1'b0, BASE + 32'd8, 32'hDEADBEEF, 5'd3, d, e, r, lat, wa);
    checks++;
    if ({e, r, d, wa} !== {1'b0, 5'd3, 32'h0, 1'b1} || lat != 1) begin
      failures++;
      $display("[TB] FAIL word_store got err=%b rd=%0d data=%h we=%b lat=%0d exp 0/3/0/1/1",
               e, r, d, wa, lat);
    end
    do_req(1'b0, 2'b10, 1'b0, BASE + 32'd8, 32'h0, 5'd9, d, e, r, lat, wa);
    checks++;
    if ({e, r, d, wa} !== {1'b0, 5'd9, 32'hDEADBEEF, 1'b0} || lat != 2) begin
      failures++;
      $display("[TB] FAIL word_load got err=%b rd=%0d data=%h we=%b lat=%0d exp 0/9/deadbeef/0/2",
               e, r, d, wa, lat);
    end
  endtask

  task automatic test_byte_half();
    logic [31:0] d; logic e; logic [4:0] r; int lat; logic wa;
    do_req(1'b0, 2'b00, 1'b0, BASE + 32'd11, 32'h0, 5'd1, d, e, r, lat, wa);
    checks++;
    if ({e, d} !== {1'b0, 32'hFFFFFFDE} || lat != 2) begin
      failures++;
      $display("[TB] FAIL byte_signed got err=%b data=%h lat=%0d exp 0/ffffffde/2", e, d, lat);
    end
    do_req(1'b0, 2'b00, 1'b1, BASE + 32'd11, 32'h0, 5'd2, d, e, r, lat, wa);
    checks++;
    if ({e, d} !== {1'b0, 32'h000000DE}) begin
      failures++;
      $display("[TB] FAIL byte_unsigned got err=%b data=%h exp 0/000000de", e, d);
    end
    do_req(1'b0, 2'b01, 1'b0, BASE + 32'd8, 32'h0, 5'd4, d, e, r, lat, wa);
    checks++;
    if ({e, d} !== {1'b0, 32'hFFFFBEEF}) begin
      failures++;
      $display("[TB] FAIL half_signed got err=%b data=%h exp 0/ffffbeef", e, d);
    end
    do_req(1'b0, 2'b01, 1'b1, BASE + 32'd8, 32'h0, 5'd5, d, e, r, lat, wa);
    checks++;
    if ({e, d} !== {1'b0, 32'h0000BEEF}) begin
      failures++;
      $display("[TB] FAIL half_unsigned got err=%b data=%h exp 0/0000beef", e, d);
    end
  endtask

  task automatic test_range();
    logic [31:0] d; logic e; logic [4:0] r; int lat; logic wa; int we_before;
    do_req(1'b1, 2'b00, 1'b0, BASE + 32'd1022, 32'h0000005A, 5'd6, d, e, r, lat, wa);
    do_req(1'b1, 2'b00, 1'b0, BASE + 32'd1023, 32'h00000081, 5'd6, d, e, r, lat, wa);
    we_before = we_count;
    do_req(1'b1, 2'b10, 1'b0, BASE + 32'd1022, 32'h11223344, 5'd10, d, e, r, lat, wa);
    checks++;
    if ({e, d, wa, r} !== {1'b1, 32'h0, 1'b0, 5'd10} || lat != 1) begin
      failures++;
      $display("[TB] FAIL oor_store got err=%b data=%h we=%b rd=%0d lat=%0d exp 1/0/0/10/1",
               e, d, wa, r, lat);
    end
    do_req(1'b0, 2'b10, 1'b0, BASE - 32'd4, 32'h0, 5'd11, d, e, r, lat, wa);
    checks++;
    if ({e, d} !== {1'b1, 32'h0} || lat != 1) begin
      failures++;
      $display("[TB] FAIL below_base got err=%b data=%h lat=%0d exp 1/0/1", e, d, lat);
    end
    do_req(1'b0, 2'b10, 1'b0, 32'hFFFF_FFFC, 32'h0, 5'd12, d, e, r, lat, wa);
    checks++;
    if (e !== 1'b1) begin
      failures++;
      $display("[TB] FAIL top_wrap got err=%b exp 1", e);
    end
    do_req(1'b1, 2'b11, 1'b0, BASE, 32'hFFFFFFFF, 5'd13, d, e, r, lat, wa);
    checks++;
    if ({e, wa} !== 2'b10) begin
      failures++;
      $display("[TB] FAIL illegal_size got err=%b we=%b exp 1/0", e, wa);
    end
    do_req(1'b0, 2'b10, 1'b0, BASE + 32'd1021, 32'h0, 5'd14, d, e, r, lat, wa);
    checks++;
    if (e !== 1'b1) begin
      failures++;
      $display("[TB] FAIL word_over_end got err=%b exp 1", e);
    end
    checks++;
    if (we_count != we_before) begin
      failures++;
      $display("[TB] FAIL fault_no_write got we_pulses=%0d exp 0", we_count - we_before);
    end
    do_req(1'b0, 2'b00, 1'b1, BASE + 32'd1022, 32'h0, 5'd15, d, e, r, lat, wa);
    checks++;
    if ({e, d} !== {1'b0, 32'h0000005A}) begin
      failures++;
      $display("[TB] FAIL readback_1022 got err=%b data=%h exp 0/0000005a", e, d);
    end
    do_req(1'b0, 2'b00, 1'b0, BASE + 32'd1023, 32'h0, 5'd16, d, e, r, lat, wa);
    checks++;
    if ({e, d} !== {1'b0, 32'hFFFFFF81}) begin
      failures++;
      $display("[TB] FAIL last_byte got err=%b data=%h exp 0/ffffff81", e, d);
    end
    do_req(1'b0, 2'b10, 1'b0, BASE + 32'd1020, 32'h0, 5'd17, d, e, r, lat, wa);
    checks++;
    if ({e, d} !== {1'b0, 32'h815A0000}) begin
      failures++;
      $display("[TB] FAIL last_word got err=%b data=%h exp 0/815a0000", e, d);
    end
  endtask

  task automatic test_misalign();
    logic [31:0] d; logic e; logic [4:0] r; int lat; logic wa;
    logic [31:0] exp_d; logic exp_e;
`ifdef LSU_MISALIGN_TRAP_EN
    exp_e = 1'b1; exp_d = 32'h0;
`else
    exp_e = 1'b0; exp_d = 32'hFFFFADBE;
`endif
    do_req(1'b0, 2'b01, 1'b0, BASE + 32'd9, 32'h0, 5'd18, d, e, r, lat, wa);
    checks++;
    if ({e, d} !== {exp_e, exp_d}) begin
      failures++;
      $display("[TB] FAIL misalign_half got err=%b data=%h exp %b/%h", e, d, exp_e, exp_d);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d; logic e; logic [4:0] r; int lat; logic wa;
    logic bad; int we_before;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b10; req_unsigned = 1'b0;
    req_addr = BASE + 32'd16; req_wdata = 32'hCAFEF00D; req_rd = 5'd12;
    @(posedge clk); #1;
    req_size = 2'b00; req_wdata = 32'h00000077; req_rd = 5'd20;
    we_before = we_count;
    bad = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if ({resp_valid, resp_rd, resp_err, resp_data, req_ready, dmem_we} !==
          {1'b1, 5'd12, 1'b0, 32'h0, 1'b0, 1'b0}) bad = 1'b1;
    end
    checks++;
    if (bad || we_count != we_before) begin
      failures++;
      $display("[TB] FAIL stall_stable got valid=%b rd=%0d err=%b ready=%b we_pulses=%0d exp 1/12/0/0/0",
               resp_valid, resp_rd, resp_err, req_ready, we_count - we_before);
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    @(negedge clk);
    checks++;
    if ({req_ready, dmem_we, resp_valid} !== 3'b110) begin
      failures++;
      $display("[TB] FAIL accept_after_hs got ready=%b we=%b valid=%b exp 1/1/0",
               req_ready, dmem_we, resp_valid);
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    checks++;
    if ({resp_valid, resp_rd} !== {1'b1, 5'd20}) begin
      failures++;
      $display("[TB] FAIL second_resp got valid=%b rd=%0d exp 1/20", resp_valid, resp_rd);
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    do_req(1'b0, 2'b10, 1'b0, BASE + 32'd16, 32'h0, 5'd21, d, e, r, lat, wa);
    checks++;
    if ({e, d, r} !== {1'b0, 32'hCAFEF077, 5'd21}) begin
      failures++;
      $display("[TB] FAIL b2b_readback got err=%b data=%h rd=%0d exp 0/cafef077/21", e, d, r);
    end
  endtask

  initial begin
    checks = 0; failures = 0; we_count = 0;
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
    req_unsigned = 1'b0; req_addr = 32'h0; req_wdata = 32'h0; req_rd = 5'd0;
    resp_ready = 1'b0;
    test_reset();
    test_store_load();
    test_byte_half();
    test_range();
    test_misalign();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lsu_dmem_ctrl.md
Name: lsu_dmem_ctrl

Overview:
Memory-stage load/store controller that sits directly upstream of the 1 KiB byte-addressable data RAM (dmem).
- Accepts one load/store request at a time from the pipeline via valid/ready.
- Range-checks and alignment-checks the address, then drives the dmem write-enable, size, 10-bit address and write data.
- For loads, captures the registered dmem read word and size-extracts/sign-extends it.
- Returns a single response (data, destination register, error) via valid/ready.

Parameters:
- DMEM_BASE, 32'h0001_0000, byte address of dmem offset 0 in the core address map.
- DMEM_BYTES, 1024, dmem size in bytes; power of two.
- AW, 10, dmem offset width; log2(DMEM_BYTES).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept; high only in IDLE.
- req_we  in  1  1=store, 0=load.
- req_size  in  2  00=byte, 01=half, 10=word, 11=illegal.
- req_unsigned  in  1  loads only: 1=zero-extend, 0=sign-extend.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data; low bytes used for byte/half.
- req_rd  in  5  destination register tag; carried to response.
- dmem_we  out  1  to dmem write enable.
- dmem_size  out  2  to dmem size.
- dmem_addr  out  AW  to dmem byte offset, req_addr - DMEM_BASE truncated to AW.
- dmem_wdata  out  32  to dmem write data.
- dmem_rdata  in  32  from dmem; registered, valid the cycle after the address is presented.
- resp_valid  out  1  response present.
- resp_ready  in  1  consumer accepts response.
- resp_data  out  32  load result; 0 for stores and errors.
- resp_rd  out  5  tag from accepted request.
- resp_err  out  1  access fault: out of range, illegal size, or misaligned.

Behaviour:
- Reset (async, rst_n=0):
  - State goes to IDLE.
  - resp_valid=0, resp_data=0, resp_rd=0, resp_err=0.
  - Latched address/size are cleared, so dmem_addr=0, dmem_size=0, dmem_we=0.
  - Reset mid-transaction abandons the request with no response.
- FSM states: IDLE, LOAD_WAIT, RESP.
- IDLE:
  - req_ready=1.
  - dmem_addr, dmem_size and dmem_wdata pass req_* through combinationally.
  - Accept when req_valid && req_ready.
  - On accept, latch addr/size/unsigned/rd and compute the fault flag.
  - Fault flag = (req_addr < DMEM_BASE) || (req_addr + bytes(size) > DMEM_BASE + DMEM_BYTES) || size==11 || misalign (misalign: see Optional Feature). Compare in 33-bit arithmetic so there is no wrap.
- Store accepted, no fault: dmem_we=1 in the accept cycle only; next state RESP with resp_err=0, resp_data=0.
- Load accepted, no fault: dmem_we=0; next state LOAD_WAIT.
- Any fault: dmem_we=0 and no dmem write occurs; next state RESP with resp_err=1, resp_data=0.
- LOAD_WAIT:
  - dmem_we=0; dmem_addr and dmem_size hold the latched values.
  - dmem_rdata holds bytes [addr..addr+3] with the addressed byte in bits [7:0], so extraction uses no shifting:
    - byte: rdata[7:0]
    - half: rdata[15:0]
    - word: rdata
  - Extend to 32 bits per req_unsigned and register into resp_data.
  - Next state RESP.
- RESP:
  - resp_valid=1; resp_* are stable until resp_ready.
  - On resp_ready, go to IDLE and drop resp_valid; outputs are registered, so there is no same-cycle re-accept.
  - dmem_we=0.
- Latency, accept to resp_valid: store/fault = 1 cycle; load = 2 cycles. Throughput is at most 1 request per 2 cycles (store) or 3 cycles (load).
- req_* inputs are ignored outside IDLE.
- Load returning the final byte offset 1023 is legal; the upper rdata bytes are don't-care and are masked by extraction.

Optional Feature:
- Macro: LSU_MISALIGN_TRAP_EN.
- Defined: half with addr[0]=1, or word with addr[1:0]!=0, is a fault (resp_err=1, no write).
- Undefined: misaligned accesses proceed to dmem unchanged (it handles unaligned bytes); only range and illegal size fault.

Test Plan:
- Reset: assert rst_n=0 mid-LOAD_WAIT -> resp_valid=0 immediately; after release, state IDLE, req_ready=1, dmem_we=0.
- Word store 32'hDEADBEEF at DMEM_BASE+8, then word load of the same address -> store resp_err=0 one cycle after accept; load resp_data=32'hDEADBEEF two cycles after accept; resp_rd matches the request tag.
- Byte loads at DMEM_BASE+11 (byte 8'hDE): signed -> resp_data=32'hFFFFFFDE; unsigned -> 32'h000000DE. Half signed at DMEM_BASE+8 -> 32'hFFFFBEEF.
- Out of range: word store at DMEM_BASE+1022 and load at DMEM_BASE-4 -> resp_err=1, dmem_we never asserted, memory unchanged on readback.
- Misalign: half load at DMEM_BASE+9 -> with LSU_MISALIGN_TRAP_EN resp_err=1; without it resp_err=0 and resp_data=32'hFFFFADBE.
- Backpressure: hold resp_ready=0 for 5 cycles -> resp_* stable, req_ready=0; the next request is accepted only after the handshake.
